fp_add_align_pipe: RTL and testbench

Parametrised, pipelined operand-alignment front end for the floating-point adder in the MAC datapath. Each cycle it accepts one pair of packed IEEE-style operands and performs the following steps:
- unpacks each operand, handling subnormals correctly;
- classifies zero, infinity and NaN;
- orders the operands by magnitude;
- right-shifts the smaller mantissa with guard/round/sticky bits.

It then hands the aligned pair to the add/normalise stage over a valid/ready handshake. Default widths give binary16.

---
 rtl/fp_add_pkg.sv | 27 ++
 rtl/fp_shift_sticky.sv | 32 +++
 rtl/fp_add_align_pipe.sv | 161 ++++++++++++++++
 tb/tb_fp_add_align_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared definitions for the floating-point add/multiply datapath.
package fp_add_pkg;

    // Default field widths give binary16.
    localparam int unsigned EXP_W_DEF = 5;
    localparam int unsigned MAN_W_DEF = 10;

    typedef enum logic [2:0] {
        ClsZero,
        ClsSubn,
        ClsNorm,
        ClsInf,
        ClsNan
    } op_class_e;

    // Operand class from the pre-reduced exponent/fraction field tests.
    function automatic op_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic frac_zero);
        if (exp_ones) begin
            return frac_zero ? ClsInf : ClsNan;
        end else if (exp_zero) begin
            return frac_zero ? ClsZero : ClsSubn;
        end
        return ClsNorm;
    endfunction

endpackage

// File: rtl/fp_shift_sticky.sv
// Combinational logical right shift that folds every shifted-out bit into bit 0.
module fp_shift_sticky #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned SH_W  = 6
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SH_W-1:0]  sh,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] mask;
    logic             lost;

    // Shift and OR the discarded bits into the sticky position.
    always_comb begin
        shifted = '0;
        mask    = '0;
        lost    = 1'b0;
        dout    = '0;
        if (32'(sh) >= WIDTH) begin
            // Everything falls off: only the sticky survives.
            dout = {{(WIDTH-1){1'b0}}, |din};
        end else begin
            shifted = din >> sh;
            mask    = ~({WIDTH{1'b1}} << sh);
            lost    = |(din & mask);
            dout    = shifted | {{(WIDTH-1){1'b0}}, lost};
        end
    end

endmodule

// File: rtl/fp_add_align_pipe.sv
// Two-stage operand alignment front end for the FP adder.
// Stage 1: unpack, classify, order by magnitude, exponent difference.
// Stage 2: sticky right shift of the smaller mantissa; drives the outputs.
module fp_add_align_pipe
    import fp_add_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   num_a,
    input  logic [EXP_W+MAN_W:0]   num_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sign_big,
    output logic                   sign_small,
    output logic                   swapped,
    output logic                   eff_sub,
    output logic [EXP_W-1:0]       exp_res,
    output logic [MAN_W+3:0]       man_big,
    output logic [MAN_W+3:0]       man_small,
    output logic                   is_nan,
    output logic                   is_inf,
    output logic                   inf_sign
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned MW = MAN_W + 4;

    // Unpack both operands.
    logic             sign_a, sign_b, hid_a, hid_b;
    logic [EXP_W-1:0] exp_a, exp_b, eff_a, eff_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    op_class_e        cls_a, cls_b;

    assign sign_a = num_a[W-1];
    assign sign_b = num_b[W-1];
    assign exp_a  = num_a[MAN_W +: EXP_W];
    assign exp_b  = num_b[MAN_W +: EXP_W];
    assign frac_a = num_a[MAN_W-1:0];
    assign frac_b = num_b[MAN_W-1:0];
    assign hid_a  = |exp_a;
    assign hid_b  = |exp_b;
    assign eff_a  = hid_a ? exp_a : EXP_W'(1);
    assign eff_b  = hid_b ? exp_b : EXP_W'(1);
    assign cls_a  = classify(exp_a == '0, &exp_a, frac_a == '0);
    assign cls_b  = classify(exp_b == '0, &exp_b, frac_b == '0);

    // Stage-1 combinational: ordering, difference and special flags.
    logic             a_big, nan_c, inf_c, inf_sign_c;
    logic             sb_c, ss_c;
    logic [EXP_W-1:0] eb_c, es_c;
    logic [MAN_W:0]   mb_c, ms_c;
    logic [EXP_W:0]   d_c;

    // Pick big/small operand (ties keep A as big) and compute special flags.
    always_comb begin
        a_big      = {eff_a, hid_a, frac_a} >= {eff_b, hid_b, frac_b};
        sb_c       = a_big ? sign_a : sign_b;
        ss_c       = a_big ? sign_b : sign_a;
        eb_c       = a_big ? eff_a : eff_b;
        es_c       = a_big ? eff_b : eff_a;
        mb_c       = a_big ? {hid_a, frac_a} : {hid_b, frac_b};
        ms_c       = a_big ? {hid_b, frac_b} : {hid_a, frac_a};
        d_c        = {1'b0, eb_c} - {1'b0, es_c};
        nan_c      = (cls_a == ClsNan) || (cls_b == ClsNan) ||
                     ((cls_a == ClsInf) && (cls_b == ClsInf) && (sign_a != sign_b));
        inf_c      = ((cls_a == ClsInf) || (cls_b == ClsInf)) && !nan_c;
        inf_sign_c = inf_c && ((cls_a == ClsInf) ? sign_a : sign_b);
    end

    // Pipeline control.
    logic v1_q, v2_q, en1, en2;

    assign en2       = !v2_q || out_ready;
    assign en1       = !v1_q || en2;
    assign in_ready  = en1 && !rst;
    assign out_valid = v2_q;

    logic             s1_sb_q, s1_ss_q, s1_swapped_q, s1_nan_q, s1_inf_q, s1_inf_sign_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [MAN_W:0]   s1_mb_q, s1_ms_q;
    logic [EXP_W:0]   s1_d_q;

    // Stage 1 register: capture a pair whenever the stage can advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q          <= 1'b0;
            s1_sb_q       <= 1'b0;
            s1_ss_q       <= 1'b0;
            s1_swapped_q  <= 1'b0;
            s1_nan_q      <= 1'b0;
            s1_inf_q      <= 1'b0;
            s1_inf_sign_q <= 1'b0;
            s1_exp_q      <= '0;
            s1_mb_q       <= '0;
            s1_ms_q       <= '0;
            s1_d_q        <= '0;
        end else if (en1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_sb_q       <= sb_c;
                s1_ss_q       <= ss_c;
                s1_swapped_q  <= !a_big;
                s1_nan_q      <= nan_c;
                s1_inf_q      <= inf_c;
                s1_inf_sign_q <= inf_sign_c;
                s1_exp_q      <= eb_c;
                s1_mb_q       <= mb_c;
                s1_ms_q       <= ms_c;
                s1_d_q        <= d_c;
            end
        end
    end

    logic [MW-1:0] small_aligned;

    fp_shift_sticky #(
        .WIDTH (MW),
        .SH_W  (EXP_W + 1)
    ) u_shift (
        .din  ({s1_ms_q, 3'b000}),
        .sh   (s1_d_q),
        .dout (small_aligned)
    );

    // Stage 2 register: holds the result stable while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q       <= 1'b0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            swapped    <= 1'b0;
            eff_sub    <= 1'b0;
            exp_res    <= '0;
            man_big    <= '0;
            man_small  <= '0;
            is_nan     <= 1'b0;
            is_inf     <= 1'b0;
            inf_sign   <= 1'b0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sign_big   <= s1_sb_q;
                sign_small <= s1_ss_q;
                swapped    <= s1_swapped_q;
                eff_sub    <= s1_sb_q ^ s1_ss_q;
                exp_res    <= s1_exp_q;
                man_big    <= {s1_mb_q, 3'b000};
                man_small  <= small_aligned;
                is_nan     <= s1_nan_q;
                is_inf     <= s1_inf_q;
                inf_sign   <= s1_inf_sign_q;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_align_pipe.sv
// Scoreboard bench for fp_add_align_pipe at binary16 widths.
module tb_fp_add_align_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] num_a, num_b;
    logic        sign_big, sign_small, swapped, eff_sub, is_nan, is_inf, inf_sign;
    logic [4:0]  exp_res;
    logic [13:0] man_big, man_small;

    always #5 clk = ~clk;

    fp_add_align_pipe #(
        .EXP_W (5),
        .MAN_W (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .num_a      (num_a),
        .num_b      (num_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .swapped    (swapped),
        .eff_sub    (eff_sub),
        .exp_res    (exp_res),
        .man_big    (man_big),
        .man_small  (man_small),
        .is_nan     (is_nan),
        .is_inf     (is_inf),
        .inf_sign   (inf_sign)
    );

    logic [39:0] dut_vec;
    assign dut_vec = {sign_big, sign_small, swapped, eff_sub, is_nan, is_inf, inf_sign,
                      exp_res, man_big, man_small};

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [39:0] sb_q[$];
    logic [39:0] held;
    logic        held_vld = 1'b0;
    logic        obs_ready, obs_valid, obs_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // Reference: compare real magnitudes, shift with an explicit sticky loop.
    function automatic logic [39:0] model(input logic [15:0] a, input logic [15:0] b);
        logic   sa, sb, sw, sbig, ssml, nan, inf, isgn, inf_a, inf_b;
        int     ea, eb, fa, fb, ma, mb, xa, xb, xbig, xsml, mbig, msml, d, sv, res;
        longint va, vb;
        sa = a[15];
        sb = b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        fa = int'(a[9:0]);
        fb = int'(b[9:0]);
        ma = (ea != 0) ? fa + 1024 : fa;
        mb = (eb != 0) ? fb + 1024 : fb;
        xa = (ea != 0) ? ea : 1;
        xb = (eb != 0) ? eb : 1;
        va = longint'(ma) << xa;
        vb = longint'(mb) << xb;
        sw = vb > va;
        sbig = sw ? sb : sa;
        ssml = sw ? sa : sb;
        xbig = sw ? xb : xa;
        xsml = sw ? xa : xb;
        mbig = sw ? mb : ma;
        msml = sw ? ma : mb;
        d  = xbig - xsml;
        sv = msml * 8;
        if (d >= 14) begin
            res = (sv != 0) ? 1 : 0;
        end else begin
            res = sv >> d;
            for (int i = 0; i < d; i++) if (((sv >> i) & 1) != 0) res = res | 1;
        end
        inf_a = (ea == 31) && (fa == 0);
        inf_b = (eb == 31) && (fb == 0);
        nan = ((ea == 31) && (fa != 0)) || ((eb == 31) && (fb != 0)) ||
              (inf_a && inf_b && (sa != sb));
        inf  = (inf_a || inf_b) && !nan;
        isgn = inf ? (inf_a ? sa : sb) : 1'b0;
        return {sbig, ssml, sw, sbig ^ ssml, nan, inf, isgn, 5'(xbig), 14'(mbig * 8), 14'(res)};
    endfunction

    // One clock cycle: drive at negedge, sample #1 later, update scoreboard.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic rdy);
        in_valid  = v;
        num_a     = a;
        num_b     = b;
        out_ready = rdy;
        #1;
        obs_ready = in_ready;
        obs_valid = out_valid;
        obs_acc   = v && in_ready;
        if (held_vld) begin
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_data", 64'(dut_vec), 64'(held));
        end
        held_vld = 1'b0;
        if (out_valid) begin
            if (rdy) begin
                check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) check_eq("result", 64'(dut_vec), 64'(sb_q.pop_front()));
            end else begin
                held     = dut_vec;
                held_vld = 1'b1;
            end
        end
        if (obs_acc) sb_q.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc > 50000) begin
            $display("FAIL cycle_budget got %0d want <=50000", cyc);
            $fatal(1);
        end
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_outputs", 64'(dut_vec), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        held_vld = 1'b0;
        @(negedge clk);
    endtask

    logic [15:0] dir_a[6] = '{16'h4480, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h7C00, 16'h0000};
    logic [15:0] dir_b[6] = '{16'hB4CD, 16'h4000, 16'h0001, 16'hFC00, 16'h3C00, 16'h8000};
    logic [15:0] specials[8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                                 16'h7E00, 16'h0001, 16'h03FF, 16'h7BFF};

    function automatic logic [15:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num_a     = '0;
        num_b     = '0;
        @(negedge clk);
        do_reset(2);

        // Directed pairs, back-to-back with no backpressure.
        for (int i = 0; i < 6; i++) cycle(1'b1, dir_a[i], dir_b[i], 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1);
        check_eq("directed_drained", 64'(sb_q.size()), 64'd0);

        // Backpressure: six pairs, out_ready low on stream cycles 3..7.
        begin
            int idx = 0;
            for (int k = 0; k < 16; k++) begin
                logic rdy;
                rdy = !(k >= 3 && k <= 7);
                cycle(idx < 6, dir_a[idx % 6] ^ 16'h0400, dir_b[idx % 6], rdy);
                if (k == 6) check_eq("bp_in_ready", 64'(obs_ready), 64'd0);
                if (obs_acc) idx++;
            end
            check_eq("bp_all_sent", 64'(idx), 64'd6);
            check_eq("bp_drained", 64'(sb_q.size()), 64'd0);
        end

        // Random traffic with random valid/ready.
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 9) < 8, pick_operand(), pick_operand(),
                  $urandom_range(0, 9) < 7);
        end

        // Fill both stages under stall, then reset mid-flight.
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h4480, 16'hB4CD, 1'b0);
        check_eq("full_in_ready", 64'(obs_ready), 64'd0);
        do_reset(1);

        // First pair after reset: visible exactly two edges after acceptance.
        cycle(1'b1, 16'h3C00, 16'h4000, 1'b1);
        check_eq("lat_accept", 64'(obs_acc), 64'd1);
        cycle(1'b0, 16'h0, 16'h0, 1'b1);
        check_eq("lat_cycle1", 64'(obs_valid), 64'd0);
        cycle(1'b0, 16'h0, 16'h0, 1'b1);
        check_eq("lat_cycle2", 64'(obs_valid), 64'd1);

        // Drain with a bound.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1);
        check_eq("final_drain", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
